cga_vram_arbiter: RTL
=====================

Name: cga_vram_arbiter

Overview:
- Shares the single-port CGA video RAM between display fetches and ISA CPU memory cycles.
- Timing comes from the CGA clock sequencer outputs (clk_seq, vram_read*, isa_op_enable).
- Display fetches are never delayed. CPU accesses are held with wait states (bus_rdy low) until an isa_op_enable window opens, then run as a fixed 3-cycle transfer.
- Sits between the ISA bus interface, the sequencer, the CRTC address path and the VRAM macro. The macro is synchronous with 1-cycle read latency.

Parameters:
- AW, 14, VRAM byte address width (16 KB).
- DW, 8, data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clk_seq  in  5  sequencer slot 0..31
- vram_read  in  1  display owns RAM address this cycle
- vram_read_a0  in  1  display address LSB
- vram_read_char  in  1  capture char byte from ram_d_in
- vram_read_att  in  1  capture attribute byte from ram_d_in
- isa_op_enable  in  1  CPU grant window
- hres_mode  in  1  80-column mode
- disp_addr  in  AW-1  CRTC word address
- bus_memr  in  1  CPU memory read strobe (synchronized, level)
- bus_memw  in  1  CPU memory write strobe (synchronized, level)
- bus_sel  in  1  address decode hit for VRAM
- bus_a  in  AW  CPU byte address
- bus_d_in  in  DW  CPU write data
- bus_d_out  out  DW  CPU read data
- bus_rdy  out  1  0 = insert ISA wait state
- ram_a  out  AW  VRAM address
- ram_d_out  out  DW  VRAM write data
- ram_we  out  1  VRAM write enable
- ram_d_in  in  DW  VRAM read data (valid 1 cycle after address)
- char_byte  out  DW  latched character byte
- att_byte  out  DW  latched attribute byte

Behaviour:
- Reset values: state IDLE, bus_rdy=1, ram_we=0, ram_a=0, bus_d_out=0, char_byte=0, att_byte=0.
- FSM states: IDLE, PEND, XFER, DONE.
  - IDLE -> PEND when req = bus_sel & (bus_memr | bus_memw). Latch bus_a, bus_d_in and the write flag.
  - PEND -> XFER in the grant cycle, defined as grant = (state==PEND) & isa_op_enable.
    - During the grant cycle: ram_a = latched address; ram_we = write flag; ram_d_out = latched data.
  - XFER -> DONE. For a read, bus_d_out <= ram_d_in.
  - DONE -> IDLE once bus_memr = bus_memw = 0. DONE holds while either strobe remains high, so one strobe gives exactly one access.
- bus_rdy is combinational: 0 when (IDLE & req), PEND or XFER; 1 otherwise. Low in the same cycle the request is first seen.
- Latency: request seen at slot 5 → grant at slot 6, XFER at 7, bus_rdy=1 at slot 8.
- Worst case: request at slot 14 → PEND over slots 15–20, grant at 21, DONE at 23.
- Display path:
  - When vram_read=1: ram_a = {disp_addr, vram_read_a0} and ram_we=0, unconditionally.
  - vram_read_char: char_byte <= ram_d_in. vram_read_att: att_byte <= ram_d_in.
- ram_a holds its last value when neither a grant nor vram_read is active.
- Collision: a grant coinciding with vram_read is impossible by sequencer design. Display wins regardless, and a simulation assertion flags it.
- Strobe dropped during PEND/XFER: the access still completes, then IDLE.
- Reset mid-operation: immediate return to IDLE. Any pending write is discarded, bus_rdy=1, ram_we=0 from the next cycle.
- hres_mode has no effect unless the optional feature is compiled in.

Optional Feature:
- Macro: CGA_SNOW_EN.
- Defined:
  - A CPU access completing (entering DONE) while hres_mode=1 sets a snow flag.
  - The next vram_read_char and vram_read_att captures load the CPU data byte instead of ram_d_in: latched write data for a write, captured data for a read.
  - The flag clears after the att capture. Reset clears it.
  - Reproduces original CGA 80-column snow.
- Undefined: no flag; captures always take ram_d_in.

Decomposition:
- Shared package cga_pkg: FSM state enum; slot constants (SLOT_CHAR=2, SLOT_ATT=3, SLOT_HCHAR=18, SLOT_HATT=19); VRAM widths.
- One natural sub-module: cga_vram_isa_fsm (request latch, FSM, bus_rdy, grant). The top level holds the address/data muxes and display latches.

Test Plan:
- Reset, then run slots 0–31 with memory preloaded 0x41 at byte 0x0100 and 0x1F at 0x0101, disp_addr=0x080. Expect char_byte=0x41 after slot 2 and att_byte=0x1F after slot 3; bus_rdy=1 throughout.
- Write 0x5A to 0x0200, strobe at slot 5. Expect bus_rdy=0 at slot 5, ram_we=1 with ram_a=0x0200 at slot 6, bus_rdy=1 at slot 8; memory[0x200]=0x5A.
- Read of 0x0200 requested at slot 14. Expect bus_rdy=0 over slots 14–22, grant at 21, bus_d_out=0x5A and bus_rdy=1 at 23; ram_we never 1.
- Reset asserted during PEND of a write. Expect IDLE next cycle, bus_rdy=1, and no ram_we pulse afterwards.
- Strobe held high for 20 cycles after DONE. Expect exactly one ram_we pulse and no re-request until the strobe drops.
- With CGA_SNOW_EN and hres_mode=1, write 0xDB at slot 8. Expect the next char_byte and att_byte = 0xDB; the following fetch pair returns memory contents. Without the macro, always memory contents.

Source files
------------

// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared types and constants for the CGA VRAM arbiter
package cga_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;

    // Sequencer slots where the display captures char/attribute bytes.
    localparam logic [4:0] SLOT_CHAR  = 5'd2;
    localparam logic [4:0] SLOT_ATT   = 5'd3;
    localparam logic [4:0] SLOT_HCHAR = 5'd18;
    localparam logic [4:0] SLOT_HATT  = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } isa_state_t;

    function automatic logic is_access(input logic sel, input logic memr, input logic memw);
        return sel & (memr | memw);
    endfunction

endpackage

// File: rtl/cga_vram_isa_fsm.sv
// rtl/cga_vram_isa_fsm.sv - ISA request latch, wait-state FSM and grant generation
module cga_vram_isa_fsm
    import cga_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          isa_op_enable,
    input  logic          bus_memr,
    input  logic          bus_memw,
    input  logic          bus_sel,
    input  logic [AW-1:0] bus_a,
    input  logic [DW-1:0] bus_d_in,
    output logic          grant,
    output logic          xfer,
    output logic          done_entry,
    output logic          wr_flag,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_data,
    output logic          bus_rdy
);

    isa_state_t state, state_next;
    logic       req;

    assign req = is_access(bus_sel, bus_memr, bus_memw);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            req_addr <= '0;
            req_data <= '0;
            wr_flag  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req) begin
                req_addr <= bus_a;
                req_data <= bus_d_in;
                wr_flag  <= bus_memw;
            end
        end
    end

    always_comb begin
        state_next = state;
        bus_rdy    = 1'b1;
        grant      = 1'b0;
        xfer       = 1'b0;
        done_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    bus_rdy    = 1'b0;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                bus_rdy = 1'b0;
                if (isa_op_enable) begin
                    grant      = 1'b1;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                bus_rdy    = 1'b0;
                xfer       = 1'b1;
                done_entry = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                // Hold until the CPU lets go so one strobe yields one access.
                if (!bus_memr && !bus_memw) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - VRAM port sharing between display and ISA CPU; CGA_SNOW_EN adds 80-column snow
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    clk_seq,
    input  logic          vram_read,
    input  logic          vram_read_a0,
    input  logic          vram_read_char,
    input  logic          vram_read_att,
    input  logic          isa_op_enable,
    input  logic          hres_mode,
    input  logic [AW-2:0] disp_addr,
    input  logic          bus_memr,
    input  logic          bus_memw,
    input  logic          bus_sel,
    input  logic [AW-1:0] bus_a,
    input  logic [DW-1:0] bus_d_in,
    output logic [DW-1:0] bus_d_out,
    output logic          bus_rdy,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d_out,
    output logic          ram_we,
    input  logic [DW-1:0] ram_d_in,
    output logic [DW-1:0] char_byte,
    output logic [DW-1:0] att_byte
);

    logic          grant;
    logic          xfer;
    logic          done_entry;
    logic          wr_flag;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [AW-1:0] ram_a_q;
    logic [DW-1:0] fetch_byte;

    cga_vram_isa_fsm #(
        .AW(AW),
        .DW(DW)
    ) u_isa_fsm (
        .clk          (clk),
        .reset        (reset),
        .isa_op_enable(isa_op_enable),
        .bus_memr     (bus_memr),
        .bus_memw     (bus_memw),
        .bus_sel      (bus_sel),
        .bus_a        (bus_a),
        .bus_d_in     (bus_d_in),
        .grant        (grant),
        .xfer         (xfer),
        .done_entry   (done_entry),
        .wr_flag      (wr_flag),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .bus_rdy      (bus_rdy)
    );

    // Display always owns the port when it asks; otherwise the address is held.
    always_comb begin
        ram_a     = ram_a_q;
        ram_we    = 1'b0;
        ram_d_out = req_data;
        if (vram_read) begin
            ram_a = {disp_addr, vram_read_a0};
        end else if (grant) begin
            ram_a  = req_addr;
            ram_we = wr_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_a_q   <= '0;
            bus_d_out <= '0;
        end else begin
            ram_a_q <= ram_a;
            if (xfer && !wr_flag) begin
                bus_d_out <= ram_d_in;
            end
        end
    end

`ifdef CGA_SNOW_EN
    logic          snow;
    logic [DW-1:0] cpu_byte;

    assign cpu_byte   = wr_flag ? req_data : bus_d_out;
    assign fetch_byte = snow ? cpu_byte : ram_d_in;

    // One CPU access in 80-column mode corrupts the next char/att pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            snow <= 1'b0;
        end else if (done_entry && hres_mode) begin
            snow <= 1'b1;
        end else if (vram_read_att) begin
            snow <= 1'b0;
        end
    end
`else
    assign fetch_byte = ram_d_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            char_byte <= '0;
            att_byte  <= '0;
        end else begin
            if (vram_read_char) begin
                char_byte <= fetch_byte;
            end
            if (vram_read_att) begin
                att_byte <= fetch_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(grant && vram_read))
            else $error("CPU grant collided with display fetch at slot %0d (hres %0b)",
                        clk_seq, hres_mode);
        end
    end

endmodule
